// File: rtl/ooo_responder_pkg.sv
// Shared constants and helpers for the out-of-order responder and its LFSR.
package ooo_responder_pkg;

    // Galois feedback taps for the 16-bit maximal-length LFSR
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Slot record layout (LSB first): busy, tag, data, cnt
    localparam int SLOT_BUSY_OFF = 0;
    localparam int SLOT_TAG_OFF  = 1;

    function automatic int slot_data_off(input int tw);
        return SLOT_TAG_OFF + tw;
    endfunction

    function automatic int slot_cnt_off(input int tw, input int w);
        return SLOT_TAG_OFF + tw + w;
    endfunction

    // Tag width includes the phase bit of the downstream queue index
    function automatic int tag_width(input int depth);
        return $clog2(depth - 1) + 1;
    endfunction

    // One Galois shift: shift right, xor taps when the bit shifted out is 1
    function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ooo_responder_lfsr16.sv
// 16-bit Galois LFSR with a reset seed; reusable by other traffic generators.
module lfsr16
    import ooo_responder_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Advance one step when enabled
    always_comb begin
        lfsr_d = en ? lfsr16_step(lfsr_q) : lfsr_q;
    end

    // State register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign state = lfsr_q;

endmodule

// File: rtl/ooo_responder.sv
// Holds tagged requests in slots for a per-request latency and emits them as
// out-of-order writes (tag stamped into the payload) for a reorder queue.
module ooo_responder
    import ooo_responder_pkg::*;
#(
    parameter int          WIDTH            = 64,
    parameter int          DEPTH            = 64,
    parameter int          D_INDEX_LOCATION = 0,
    parameter int          SLOTS            = 8,
    parameter int          LAT_WIDTH        = 4,
    parameter int          MIN_LAT          = 1,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    localparam int         TW               = tag_width(DEPTH),
    localparam int         OW               = $clog2(SLOTS) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TW-1:0]        req_tag,
    input  logic [WIDTH-1:0]     req_data,
    input  logic                 fixed_lat_en,
    input  logic [LAT_WIDTH-1:0] fixed_lat,
    output logic                 rsp_wr_en,
    output logic [WIDTH-1:0]     rsp_d,
    output logic [OW-1:0]        occupancy,
    output logic                 busy
);

    localparam int IW       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BUSY_B   = SLOT_BUSY_OFF;
    localparam int TAG_LSB  = SLOT_TAG_OFF;
    localparam int DATA_LSB = slot_data_off(TW);
    localparam int CNT_LSB  = slot_cnt_off(TW, WIDTH);
    localparam int SW       = CNT_LSB + LAT_WIDTH;

    logic [SW-1:0]        slot_q [SLOTS];
    logic [SW-1:0]        slot_d [SLOTS];
    logic                 rsp_wr_en_q, rsp_wr_en_d;
    logic [WIDTH-1:0]     rsp_d_q, rsp_d_d;
    logic [OW-1:0]        occ_q, occ_d;

    logic                 free_found, iss_found, accept;
    logic [IW-1:0]        free_idx, iss_idx;
    logic [LAT_WIDTH-1:0] lat_raw, lat_floor, lat;
    logic [15:0]          lfsr_state;
    logic                 unused_lfsr_hi;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .state (lfsr_state)
    );

    // Only the low LAT_WIDTH bits feed the latency
    assign unused_lfsr_hi = ^lfsr_state[15:LAT_WIDTH];

    // Lowest-index free slot and lowest-index eligible (cnt==0) slot,
    // both from registered state so a slot freed this edge is not reused
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slot_q[i][BUSY_B]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (slot_q[i][BUSY_B] && (slot_q[i][CNT_LSB +: LAT_WIDTH] == '0)) begin
                iss_found = 1'b1;
                iss_idx   = IW'(i);
            end
        end
    end

    assign req_ready = free_found;
    assign accept    = req_valid && free_found;

    // Latency for an incoming request: fixed value floored at 1, or LFSR floored at MIN_LAT
    always_comb begin
        lat_raw   = fixed_lat_en ? fixed_lat : lfsr_state[LAT_WIDTH-1:0];
        lat_floor = fixed_lat_en ? LAT_WIDTH'(1) : LAT_WIDTH'(MIN_LAT);
        lat       = (lat_raw < lat_floor) ? lat_floor : lat_raw;
    end

    // Next slot state: countdown, issue of one eligible slot, accept into a free slot
    always_comb begin
        rsp_wr_en_d = 1'b0;
        rsp_d_d     = rsp_d_q;
        for (int i = 0; i < SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            if (slot_q[i][BUSY_B] && (slot_q[i][CNT_LSB +: LAT_WIDTH] != '0)) begin
                slot_d[i][CNT_LSB +: LAT_WIDTH] = slot_q[i][CNT_LSB +: LAT_WIDTH] - LAT_WIDTH'(1);
            end
        end
        if (iss_found) begin
            rsp_wr_en_d = 1'b1;
            rsp_d_d     = slot_q[iss_idx][DATA_LSB +: WIDTH];
            rsp_d_d[D_INDEX_LOCATION +: TW] = slot_q[iss_idx][TAG_LSB +: TW];
            slot_d[iss_idx][BUSY_B] = 1'b0;
        end
        // accept targets a free slot, so it never collides with the issuing slot
        if (accept) begin
            slot_d[free_idx] = {lat, req_data, req_tag, 1'b1};
        end
        occ_d = occ_q + OW'(accept) - OW'(iss_found);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
            rsp_wr_en_q <= 1'b0;
            rsp_d_q     <= '0;
            occ_q       <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= slot_d[i];
            rsp_wr_en_q <= rsp_wr_en_d;
            rsp_d_q     <= rsp_d_d;
            occ_q       <= occ_d;
        end
    end

    assign rsp_wr_en = rsp_wr_en_q;
    assign rsp_d     = rsp_d_q;
    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

endmodule
